// File: rtl/sha3_pkg.sv
// Shared SHA3 constants, lane addressing and byte-order helpers.
// Used by the squeeze-side reader and anything that indexes the 1600-bit state.
package sha3_pkg;

  localparam int unsigned LANE_W            = 64;
  localparam int unsigned STATE_W           = 1600;
  localparam int unsigned SHA3_512_DIGEST_W = 512;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } squeeze_state_t;

  // Bit offset of lane (x,y) inside the flattened state vector.
  function automatic int unsigned lane_base(input int unsigned x, input int unsigned y);
    return LANE_W * (x + 5 * y);
  endfunction

  // Reverses the low nbytes bytes of d; bytes above nbytes come back as zero.
  function automatic logic [63:0] byte_swap(input logic [63:0] d, input int unsigned nbytes);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbytes) r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_digest_squeezer.sv
// Captures the digest lanes of the final Keccak state and streams them out word by word.
// Latency: first word valid the cycle after capture; backpressure holds the word until dout_ready.
module sha3_digest_squeezer
  import sha3_pkg::*;
#(
  parameter int OUT_W          = 32,
  parameter int DIGEST_W       = SHA3_512_DIGEST_W,
  parameter bit BIG_ENDIAN_OUT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_valid,
  output logic               state_ready,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy
);

  localparam int N     = DIGEST_W / OUT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  squeeze_state_t      fsm_q;
  logic [DIGEST_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dout_valid_q;
  logic                dout_last_q;
  logic                state_ready_q;
  logic [OUT_W-1:0]    word_lo;

  // Lanes beyond the digest are never consumed by this reader.
  logic unused_state_hi;
  assign unused_state_hi = ^state_in[STATE_W-1:DIGEST_W];

  assign shift_d = shift_q >> OUT_W;
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      dout_valid_q  <= 1'b0;
      dout_last_q   <= 1'b0;
      state_ready_q <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (state_valid) begin
            fsm_q         <= SEND;
            shift_q       <= state_in[DIGEST_W-1:0];
            cnt_q         <= '0;
            dout_valid_q  <= 1'b1;
            dout_last_q   <= (N == 1);
            state_ready_q <= 1'b0;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (cnt_q == LAST_CNT) begin
              fsm_q         <= IDLE;
              shift_q       <= '0;
              cnt_q         <= '0;
              dout_valid_q  <= 1'b0;
              dout_last_q   <= 1'b0;
              state_ready_q <= 1'b1;
            end else begin
              shift_q     <= shift_d;
              cnt_q       <= cnt_d;
              dout_last_q <= (cnt_d == LAST_CNT);
            end
          end
        end
        default: begin
          fsm_q         <= IDLE;
          dout_valid_q  <= 1'b0;
          dout_last_q   <= 1'b0;
          state_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The shift register is zero outside SEND, so dout reads zero while idle.
  assign word_lo = shift_q[OUT_W-1:0];
  assign dout    = BIG_ENDIAN_OUT ? OUT_W'(byte_swap(64'(word_lo), OUT_W / 8)) : word_lo;

  assign dout_valid  = dout_valid_q;
  assign dout_last   = dout_last_q;
  assign state_ready = state_ready_q;
  assign busy        = (fsm_q == SEND);

endmodule

// File: tb/tb_sha3_digest_squeezer.sv
// Scoreboard bench for sha3_digest_squeezer: a little-endian and a big-endian instance share the inputs.
module tb_sha3_digest_squeezer;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1599:0] state_in = '0;
  logic          state_valid = 1'b0;
  logic          dout_ready = 1'b0;

  logic        state_ready, dout_valid, dout_last, busy;
  logic [31:0] dout;
  logic        state_ready_be, dout_valid_be, dout_last_be, busy_be;
  logic [31:0] dout_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_be_q[$];

  always #5 clk = ~clk;

  sha3_digest_squeezer #(.OUT_W(32), .DIGEST_W(512), .BIG_ENDIAN_OUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
    .state_ready(state_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy)
  );

  sha3_digest_squeezer #(.OUT_W(32), .DIGEST_W(512), .BIG_ENDIAN_OUT(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .state_valid(state_valid),
    .state_ready(state_ready_be), .dout(dout_be), .dout_valid(dout_valid_be),
    .dout_ready(dout_ready), .dout_last(dout_last_be), .busy(busy_be)
  );

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Digest given as the usual hex string (byte 0 leftmost); upper lanes filled with noise.
  function automatic logic [1599:0] make_state(input logic [511:0] dig);
    logic [1599:0] s;
    s = rand_state();
    for (int i = 0; i < 64; i++) s[8*i +: 8] = dig[511-8*i -: 8];
    return s;
  endfunction

  task automatic push_words(input logic [1599:0] s);
    logic [7:0] b0, b1, b2, b3;
    for (int k = 0; k < 16; k++) begin
      b0 = s[8*(4*k)   +: 8];
      b1 = s[8*(4*k+1) +: 8];
      b2 = s[8*(4*k+2) +: 8];
      b3 = s[8*(4*k+3) +: 8];
      exp_q.push_back({b3, b2, b1, b0});
      exp_be_q.push_back({b0, b1, b2, b3});
    end
  endtask

  // Presents s for one capture edge; returns at the first SEND-cycle negedge.
  task automatic capture(input logic [1599:0] s);
    state_in    = s;
    state_valid = 1'b1;
    push_words(s);
    @(negedge clk);
    state_valid = 1'b0;
    state_in    = rand_state();
  endtask

  task automatic test_reset();
    #12;
    rst_n = 1'b0;
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    total++; if (dout_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", dout_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL rst_dout: got %h want 0", dout); end
    total++; if (state_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", state_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    logic [511:0]  kv, rec;
    logic [31:0]   ew, eb;
    kv = 512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;
    rec = '0;
    dout_ready = 1'b1;
    capture(make_state(kv));
    for (int k = 0; k < 16; k++) begin
      ew = exp_q.pop_front();
      eb = exp_be_q.pop_front();
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL kv_valid[%0d]: got %b want 1", k, dout_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL kv_busy[%0d]: got %b want 1", k, busy); end
      total++; if (dout !== ew) begin bad++; $display("FAIL kv_word[%0d]: got %h want %h", k, dout, ew); end
      total++; if (dout_be !== eb) begin bad++; $display("FAIL kv_be_word[%0d]: got %h want %h", k, dout_be, eb); end
      total++; if (dout_last !== (k == 15)) begin bad++; $display("FAIL kv_last[%0d]: got %b want %b", k, dout_last, (k == 15)); end
      if (k == 0) begin
        total++; if (dout !== 32'hcc739fa6) begin bad++; $display("FAIL kv_w0: got %h want cc739fa6", dout); end
        total++; if (dout_be !== 32'ha69f73cc) begin bad++; $display("FAIL kv_be_w0: got %h want a69f73cc", dout_be); end
      end
      if (k == 1) begin
        total++; if (dout !== 32'hc59a3aa2) begin bad++; $display("FAIL kv_w1: got %h want c59a3aa2", dout); end
      end
      if (k == 15) begin
        total++; if (dout !== 32'h26cd1d28) begin bad++; $display("FAIL kv_w15: got %h want 26cd1d28", dout); end
      end
      rec[511-32*k -: 32] = {dout[7:0], dout[15:8], dout[23:16], dout[31:24]};
      @(negedge clk);
    end
    total++; if (rec !== kv) begin bad++; $display("FAIL kv_digest: got %h want %h", rec, kv); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL kv_idle_valid: got %b want 0", dout_valid); end
    total++; if (state_ready !== 1'b1) begin bad++; $display("FAIL kv_idle_ready: got %b want 1", state_ready); end
  endtask

  task automatic test_backpressure();
    int          received, stall, cyc;
    logic        have_prev;
    logic [31:0] prev, ew, eb;
    received = 0; stall = 0; cyc = 0; have_prev = 1'b0; prev = '0;
    dout_ready = 1'b1;
    capture(rand_state());
    while (received < 16 && cyc < 300) begin
      if (received == 3 && stall < 5) begin
        dout_ready = 1'b0;
        stall++;
        total++; if (dout !== exp_q[0]) begin bad++; $display("FAIL bp_stall_word: got %h want %h", dout, exp_q[0]); end
      end else if (received < 3) begin
        dout_ready = 1'b1;
      end else begin
        dout_ready = 1'($urandom_range(0, 1));
      end
      if (have_prev) begin
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_drop: got %b want 1", dout_valid); end
        total++; if (dout !== prev) begin bad++; $display("FAIL bp_hold: got %h want %h", dout, prev); end
      end
      if (dout_valid === 1'b1 && dout_ready) begin
        ew = exp_q.pop_front();
        eb = exp_be_q.pop_front();
        total++; if (dout !== ew) begin bad++; $display("FAIL bp_word[%0d]: got %h want %h", received, dout, ew); end
        total++; if (dout_be !== eb) begin bad++; $display("FAIL bp_be_word[%0d]: got %h want %h", received, dout_be, eb); end
        total++; if (dout_last !== (received == 15)) begin bad++; $display("FAIL bp_last[%0d]: got %b want %b", received, dout_last, (received == 15)); end
        received++;
        have_prev = 1'b0;
      end else if (dout_valid === 1'b1) begin
        have_prev = 1'b1;
        prev = dout;
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (received != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", received); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid: got %b want 0", dout_valid); end
    exp_q.delete();
    exp_be_q.delete();
    dout_ready = 1'b1;
  endtask

  task automatic test_capture_while_busy();
    logic [1599:0] sa, sb;
    logic [31:0]   ew;
    sa = rand_state();
    sb = rand_state();
    dout_ready = 1'b1;
    capture(sa);
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        state_valid = 1'b1;
        state_in    = sb;
        total++; if (state_ready !== 1'b0) begin bad++; $display("FAIL cwb_ready: got %b want 0", state_ready); end
      end else if (k == 7) begin
        state_valid = 1'b0;
      end
      ew = exp_q.pop_front();
      void'(exp_be_q.pop_front());
      total++; if (dout !== ew) begin bad++; $display("FAIL cwb_word[%0d]: got %h want %h", k, dout, ew); end
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL cwb_valid[%0d]: got %b want 1", k, dout_valid); end
      @(negedge clk);
    end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cwb_idle_valid: got %b want 0", dout_valid); end
    total++; if (state_ready !== 1'b1) begin bad++; $display("FAIL cwb_idle_ready: got %b want 1", state_ready); end
    capture(sb);
    for (int k = 0; k < 16; k++) begin
      ew = exp_q.pop_front();
      void'(exp_be_q.pop_front());
      total++; if (dout !== ew) begin bad++; $display("FAIL cwb_b_word[%0d]: got %h want %h", k, dout, ew); end
      @(negedge clk);
    end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL cwb_b_idle: got %b want 0", dout_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ew;
    dout_ready = 1'b1;
    capture(rand_state());
    for (int k = 0; k < 8; k++) begin
      ew = exp_q.pop_front();
      void'(exp_be_q.pop_front());
      total++; if (dout !== ew) begin bad++; $display("FAIL rm_word[%0d]: got %h want %h", k, dout, ew); end
      if (k < 7) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", dout_valid); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL rm_dout: got %h want 0", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    total++; if (dout_last !== 1'b0) begin bad++; $display("FAIL rm_last: got %b want 0", dout_last); end
    exp_q.delete();
    exp_be_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (state_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", state_ready); end
    capture(rand_state());
    for (int k = 0; k < 16; k++) begin
      ew = exp_q.pop_front();
      void'(exp_be_q.pop_front());
      total++; if (dout !== ew) begin bad++; $display("FAIL rm_new_word[%0d]: got %h want %h", k, dout, ew); end
      total++; if (dout_last !== (k == 15)) begin bad++; $display("FAIL rm_new_last[%0d]: got %b want %b", k, dout_last, (k == 15)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [1599:0] s;
    logic [31:0]   ew, eb;
    dout_ready  = 1'b1;
    s           = rand_state();
    state_in    = s;
    state_valid = 1'b1;
    push_words(s);
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        ew = exp_q.pop_front();
        eb = exp_be_q.pop_front();
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d][%0d]: got %b want 1", d, k, dout_valid); end
        total++; if (dout !== ew) begin bad++; $display("FAIL b2b_word[%0d][%0d]: got %h want %h", d, k, dout, ew); end
        total++; if (dout_be !== eb) begin bad++; $display("FAIL b2b_be_word[%0d][%0d]: got %h want %h", d, k, dout_be, eb); end
      end
      @(negedge clk);
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble_valid[%0d]: got %b want 0", d, dout_valid); end
      total++; if (state_ready !== 1'b1) begin bad++; $display("FAIL b2b_bubble_ready[%0d]: got %b want 1", d, state_ready); end
      if (d < 2) begin
        s        = rand_state();
        state_in = s;
        push_words(s);
      end else begin
        state_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %b want 0", dout_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_capture_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
